loopback_nch: RTL

LOOPBACK_NCH -- requirements
Module: loopback_nch

---
 rtl/loopback_fifo.sv | 46 ++++
 rtl/loopback_nch.sv | 61 ++++++
 2 files changed

// File: rtl/loopback_fifo.sv
// loopback_fifo: single-channel byte FIFO with valid/ready on both sides.
// Storage has no reset so it can map onto distributed or block RAM.
module loopback_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    input  logic       rd_ready_i
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign wr_ready_o = r_count != (AW+1)'(DEPTH);
    assign rd_valid_o = r_count != '0;
    // Mask the head while empty so unreset storage never leaks X onto the output
    assign rd_data_o  = rd_valid_o ? r_mem[r_rptr] : 8'h00;
    assign w_push     = wr_valid_i && wr_ready_o;
    assign w_pop      = rd_valid_o && rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/loopback_nch.sv
// loopback_nch: per-channel byte loopback through FIFOs, with optional channel
// rotation and a stretched activity LED.
module loopback_nch #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int ROTATE   = 0,
    parameter int LED_BITS = 22
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [8*CHANNELS-1:0] out_data_i,
    input  logic [CHANNELS-1:0]   out_valid_i,
    output logic [CHANNELS-1:0]   out_ready_o,
    output logic [8*CHANNELS-1:0] in_data_o,
    output logic [CHANNELS-1:0]   in_valid_o,
    input  logic [CHANNELS-1:0]   in_ready_i,
    output logic                  led_o
);
    logic [CHANNELS-1:0] w_wr_ready;
    logic [LED_BITS-1:0] r_act;
    logic [LED_BITS-1:0] w_act_nxt;
    logic                r_led;

    genvar d, s;
    for (d = 0; d < CHANNELS; d++) begin : g_dst
        localparam int SRC = (ROTATE != 0) ? (d + CHANNELS - 1) % CHANNELS : d;
        loopback_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .wr_data_i  (out_data_i[8*SRC +: 8]),
            .wr_valid_i (out_valid_i[SRC]),
            .wr_ready_o (w_wr_ready[d]),
            .rd_data_o  (in_data_o[8*d +: 8]),
            .rd_valid_o (in_valid_o[d]),
            .rd_ready_i (in_ready_i[d])
        );
    end

    for (s = 0; s < CHANNELS; s++) begin : g_src
        localparam int DST = (ROTATE != 0) ? (s + 1) % CHANNELS : s;
        assign out_ready_o[s] = w_wr_ready[DST];
    end

    always_comb begin
        w_act_nxt = r_act;
        if (|(out_valid_i & out_ready_o)) w_act_nxt = '1;
        else if (r_act != '0) w_act_nxt = r_act - LED_BITS'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_act <= '0;
            r_led <= 1'b0;
        end else begin
            r_act <= w_act_nxt;
            r_led <= w_act_nxt != '0;
        end
    end

    assign led_o = r_led;
endmodule
